mips_prog_loader: RTL and testbench

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

---
 rtl/mips_prog_loader.sv | 129 ++++++++++++
 tb/tb_mips_prog_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// Streams a program into MIPS instruction memory, then releases the core and waits for HALT.
// Optional halt-word padding after the last word: define MIPS_LOADER_HLT_PAD_EN.
//
// state | meaning
// LOAD  | accept program words, cpu held
// PAD   | append one HLT_WORD after the last word (MIPS_LOADER_HLT_PAD_EN only)
// START | one-cycle cpu_start pulse, cpu still held
// RUN   | cpu running, waiting for cpu_halted
// DONE  | program halted, waiting for load_req
module mips_prog_loader #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] HLT_WORD = 32'hfc000000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  input  logic              load_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  input  logic              cpu_halted,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow
);

  typedef enum logic [2:0] {
    ST_LOAD,
`ifdef MIPS_LOADER_HLT_PAD_EN
    ST_PAD,
`endif
    ST_START,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              xfer;
  logic              ptr_full;
  logic [31:0]       wdata_nxt;

  assign s_ready   = (state == ST_LOAD);
  assign xfer      = s_valid && s_ready;
  assign ptr_full  = &wr_ptr;
  assign wdata_nxt = s_ready ? s_data : HLT_WORD;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_LOAD;
      wr_ptr       <= '0;
      word_count   <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      cpu_start    <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (xfer) begin
            mem_we     <= 1'b1;
            mem_addr   <= wr_ptr;
            mem_wdata  <= wdata_nxt;
            wr_ptr     <= wr_ptr + 1'b1;
            word_count <= word_count + 1'b1;
            if (s_last) begin
`ifdef MIPS_LOADER_HLT_PAD_EN
              state     <= ST_PAD;
`else
              state     <= ST_START;
              cpu_start <= 1'b1;
`endif
            end else if (ptr_full) begin
              err_overflow <= 1'b1;
              state        <= ST_START;
              cpu_start    <= 1'b1;
            end
          end
        end
`ifdef MIPS_LOADER_HLT_PAD_EN
        ST_PAD: begin
          // word_count MSB set means memory is already full: nothing to pad
          if (!word_count[ADDR_W]) begin
            mem_we     <= 1'b1;
            mem_addr   <= wr_ptr;
            mem_wdata  <= wdata_nxt;
            wr_ptr     <= wr_ptr + 1'b1;
            word_count <= word_count + 1'b1;
          end
          state     <= ST_START;
          cpu_start <= 1'b1;
        end
`endif
        ST_START: begin
          state    <= ST_RUN;
          cpu_hold <= 1'b0;
        end
        ST_RUN: begin
          if (cpu_halted) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (load_req) begin
            state        <= ST_LOAD;
            done         <= 1'b0;
            wr_ptr       <= '0;
            word_count   <= '0;
            err_overflow <= 1'b0;
            cpu_hold     <= 1'b1;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: a default-size instance plus an ADDR_W=2 instance for overflow.
// Expectations follow MIPS_LOADER_HLT_PAD_EN when it is defined.
module tb_mips_prog_loader;

`ifdef MIPS_LOADER_HLT_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst_n;
  logic        s_valid, s_ready, s_last, load_req;
  logic [31:0] s_data;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold, cpu_start, cpu_halted, done, err_overflow;
  logic [10:0] word_count;

  logic        s_valid2, s_ready2, s_last2, load_req2;
  logic [31:0] s_data2;
  logic        mem_we2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic        cpu_hold2, cpu_start2, cpu_halted2, done2, err_overflow2;
  logic [2:0]  word_count2;

  mips_prog_loader u_dut (
    .clk1(clk1), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .load_req(load_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .cpu_start(cpu_start),
    .cpu_halted(cpu_halted), .done(done), .word_count(word_count), .err_overflow(err_overflow)
  );

  mips_prog_loader #(.ADDR_W(2)) u_dut_small (
    .clk1(clk1), .rst_n(rst_n), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .s_last(s_last2), .load_req(load_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .cpu_hold(cpu_hold2), .cpu_start(cpu_start2),
    .cpu_halted(cpu_halted2), .done(done2), .word_count(word_count2), .err_overflow(err_overflow2)
  );

  logic [31:0] log_addr[$], log_data[$], log_addr2[$], log_data2[$];

  always @(negedge clk1) begin
    if (mem_we) begin
      log_addr.push_back({22'd0, mem_addr});
      log_data.push_back(mem_wdata);
    end
    if (mem_we2) begin
      log_addr2.push_back({30'd0, mem_addr2});
      log_data2.push_back(mem_wdata2);
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int pulses;
  int nlog;
  logic [31:0] prog_a[9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; i < 20 && !s_ready; i++) tick;
    check("send_ready", {31'd0, s_ready}, 32'd1);
    tick;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    for (int i = 0; i < 20 && cpu_hold; i++) tick;
    check({tag, "_released"}, {31'd0, cpu_hold}, 32'd0);
    cpu_halted = 1'b1;
    tick;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic reload(input string tag);
    load_req   = 1'b1;
    cpu_halted = 1'b0;
    tick;
    load_req = 1'b0;
    check({tag, "_reload_done"}, {31'd0, done}, 32'd0);
    check({tag, "_reload_wc"}, {21'd0, word_count}, 32'd0);
    check({tag, "_reload_ready"}, {31'd0, s_ready}, 32'd1);
    check({tag, "_reload_hold"}, {31'd0, cpu_hold}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_valid = 0; s_last = 0; s_data = 0; load_req = 0; cpu_halted = 0;
    s_valid2 = 0; s_last2 = 0; s_data2 = 0; load_req2 = 0; cpu_halted2 = 0;
    #12;
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_start", {31'd0, cpu_start}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wc", {21'd0, word_count}, 32'd0);
    check("rst_err", {31'd0, err_overflow}, 32'd0);
    check("rst_ready", {31'd0, s_ready}, 32'd1);
    rst_n = 1'b1;
    tick;

    // 9-word program, back to back
    log_addr.delete(); log_data.delete();
    for (int i = 0; i < 9; i++) send(prog_a[i], i == 8);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (cpu_start) pulses++;
      tick;
    end
    check("a_pulses", pulses, 32'd1);
    check("a_hold", {31'd0, cpu_hold}, 32'd0);
    check("a_wc", {21'd0, word_count}, 9 + PAD);
    check("a_nwr", log_addr.size(), 9 + PAD);
    for (int i = 0; i < 9; i++) begin
      check("a_addr", log_addr[i], i);
      check("a_data", log_data[i], prog_a[i]);
    end
`ifdef MIPS_LOADER_HLT_PAD_EN
    check("a_pad_addr", log_addr[9], 32'd9);
    check("a_pad_data", log_data[9], 32'hfc000000);
`endif
    check("a_notdone", {31'd0, done}, 32'd0);
    finish_run("a");
    reload("a");

    // 3 words ending in 00222000; load_req in RUN then in DONE
    log_addr.delete(); log_data.delete();
    send(32'h28010005, 1'b0);
    send(32'h28020007, 1'b0);
    send(32'h00222000, 1'b1);
    for (int i = 0; i < 20 && cpu_hold; i++) tick;
    tick;
    check("c_nwr", log_addr.size(), 3 + PAD);
    check("c_wc", {21'd0, word_count}, 3 + PAD);
    check("c_last_data", log_data[2], 32'h00222000);
`ifdef MIPS_LOADER_HLT_PAD_EN
    check("c_pad_addr", log_addr[3], 32'd3);
    check("c_pad_data", log_data[3], 32'hfc000000);
`endif
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    check("c_run_req_done", {31'd0, done}, 32'd0);
    check("c_run_req_hold", {31'd0, cpu_hold}, 32'd0);
    check("c_run_req_ready", {31'd0, s_ready}, 32'd0);
    check("c_run_req_wc", {21'd0, word_count}, 3 + PAD);
    cpu_halted = 1'b1;
    tick;
    check("c_done", {31'd0, done}, 32'd1);
    reload("c");

    // s_valid toggling, s_last driven high while s_valid is low
    log_addr.delete(); log_data.delete();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 32'h1000 + i; s_last = (i == 2);
      check("d_ready", {31'd0, s_ready}, 32'd1);
      tick;
      check("d_we", {31'd0, mem_we}, 32'd1);
      check("d_addr", {22'd0, mem_addr}, i);
      s_valid = 1'b0; s_last = 1'b1;
      if (i < 2) begin
        tick;
        check("d_idle_we", {31'd0, mem_we}, 32'd0);
        check("d_idle_ready", {31'd0, s_ready}, 32'd1);
      end
    end
    s_last = 1'b0;
    finish_run("d");
    check("d_nwr", log_addr.size(), 3 + PAD);
    for (int i = 0; i < 3; i++) check("d_log_addr", log_addr[i], i);
    reload("d");

    // reset after 2 of 5 words
    log_addr.delete(); log_data.delete();
    send(32'h0000aaa0, 1'b0);
    send(32'h0000aaa1, 1'b0);
    check("e_we_before", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("e_we_rst", {31'd0, mem_we}, 32'd0);
    check("e_hold_rst", {31'd0, cpu_hold}, 32'd1);
    check("e_wc_rst", {21'd0, word_count}, 32'd0);
    nlog = log_addr.size();
    check("e_prelog", nlog, 32'd1);
    tick; tick;
    check("e_nolog", log_addr.size(), nlog);
    rst_n = 1'b1;
    log_addr.delete(); log_data.delete();
    for (int i = 0; i < 5; i++) send(32'h0000bbb0 + i, i == 4);
    tick; tick;
    check("e_nwr", log_addr.size(), 5 + PAD);
    check("e_first_addr", log_addr[0], 32'd0);
    check("e_first_data", log_data[0], 32'h0000bbb0);
    check("e_wc", {21'd0, word_count}, 5 + PAD);
    finish_run("e");

    // ADDR_W=2: 5 words, s_last only on the 5th -> overflow
    log_addr2.delete(); log_data2.delete();
    for (int i = 0; i < 4; i++) begin
      s_valid2 = 1'b1; s_data2 = 32'ha0 + i; s_last2 = 1'b0;
      check("f_ready", {31'd0, s_ready2}, 32'd1);
      tick;
    end
    check("f_err", {31'd0, err_overflow2}, 32'd1);
    check("f_start", {31'd0, cpu_start2}, 32'd1);
    check("f_we4", {31'd0, mem_we2}, 32'd1);
    check("f_addr4", {30'd0, mem_addr2}, 32'd3);
    s_data2 = 32'ha4; s_last2 = 1'b1;
    check("f_ready5", {31'd0, s_ready2}, 32'd0);
    tick;
    check("f_ready5b", {31'd0, s_ready2}, 32'd0);
    check("f_start_off", {31'd0, cpu_start2}, 32'd0);
    check("f_hold", {31'd0, cpu_hold2}, 32'd0);
    tick;
    s_valid2 = 1'b0; s_last2 = 1'b0;
    check("f_nwr", log_addr2.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("f_log_addr", log_addr2[i], i);
      check("f_log_data", log_data2[i], 32'ha0 + i);
    end
    check("f_wc", {29'd0, word_count2}, 32'd4);
    check("f_err_hold", {31'd0, err_overflow2}, 32'd1);

    // ADDR_W=2: s_last exactly at full capacity, no pad write, no overflow
    cpu_halted2 = 1'b1;
    tick;
    check("g_done", {31'd0, done2}, 32'd1);
    load_req2 = 1'b1; cpu_halted2 = 1'b0;
    tick;
    load_req2 = 1'b0;
    check("g_err_clr", {31'd0, err_overflow2}, 32'd0);
    check("g_wc_clr", {29'd0, word_count2}, 32'd0);
    log_addr2.delete(); log_data2.delete();
    for (int i = 0; i < 4; i++) begin
      s_valid2 = 1'b1; s_data2 = 32'hc0 + i; s_last2 = (i == 3);
      tick;
    end
    s_valid2 = 1'b0; s_last2 = 1'b0;
    tick; tick; tick;
    check("g_nwr", log_addr2.size(), 32'd4);
    check("g_wc", {29'd0, word_count2}, 32'd4);
    check("g_err", {31'd0, err_overflow2}, 32'd0);
    check("g_hold", {31'd0, cpu_hold2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
